pwm_ton_sequencer: RTL and testbench

//  Serialises Ton updates from the CPU side (PIO/Avalon glue) onto the shared Ton bus of the multi-PWM core.

---
 rtl/pwm_ton_sequencer.sv | 130 +++++++++++++
 tb/tb_pwm_ton_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ton_sequencer.sv
// pwm_ton_sequencer: queues CPU Ton updates and serialises them onto the shared Ton bus with latch strobes
module pwm_ton_sequencer #(
    parameter int NB_CH      = 25,
    parameter int TON_W      = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_ch,
    input  logic [TON_W-1:0] req_ton,
    input  logic             req_en,
    output logic [TON_W-1:0] ton_out,
    output logic [NB_CH-1:0] latch_out,
    output logic [NB_CH-1:0] oe_out,
    output logic             busy,
    output logic             err_ch,
    input  logic             err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [4:0]       mem_ch  [FIFO_DEPTH];
    logic [TON_W-1:0] mem_ton [FIFO_DEPTH];
    logic             mem_en  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [4:0]       cur_ch;
    logic             cur_en;
    logic             fifo_empty, accept, ch_bad, push, pop, to_strobe;
    logic [NB_CH-1:0] sel;

    assign fifo_empty = count == '0;
    assign req_ready  = count != (AW+1)'(FIFO_DEPTH);
    assign accept     = req_valid && req_ready;
    assign ch_bad     = req_ch >= 5'(NB_CH) && req_ch != 5'h1F;
    assign push       = accept && !ch_bad;
    assign busy       = state != IDLE || !fifo_empty;
    assign sel        = cur_ch == 5'h1F ? '1 : NB_CH'(1) << cur_ch;

    // next-state: pop when idle or when a hold window expires, count down setup/hold windows
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        pop       = 1'b0;
        to_strobe = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop      = 1'b1;
                state_nx = SETUP;
                cnt_nx   = CW'(SETUP_CYC - 1);
            end
            SETUP: if (cnt == '0) begin
                state_nx  = STROBE;
                to_strobe = 1'b1;
            end else cnt_nx = cnt - CW'(1);
            STROBE: begin
                state_nx = HOLD;
                cnt_nx   = CW'(HOLD_CYC - 1);
            end
            HOLD: if (cnt == '0) begin
                pop      = !fifo_empty;
                state_nx = fifo_empty ? IDLE : SETUP;
                cnt_nx   = CW'(SETUP_CYC - 1);
            end else cnt_nx = cnt - CW'(1);
            default: state_nx = IDLE;
        endcase
    end

    // FSM state and window counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // FIFO storage; contents need no reset since pointers and count gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ch[wr_ptr]  <= req_ch;
            mem_ton[wr_ptr] <= req_ton;
            mem_en[wr_ptr]  <= req_en;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Ton bus, strobes, output enables and sticky channel error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ton_out   <= '0;
            latch_out <= '0;
            oe_out    <= '0;
            cur_ch    <= '0;
            cur_en    <= 1'b0;
            err_ch    <= 1'b0;
        end else begin
            if (pop) begin
                ton_out <= mem_ton[rd_ptr];
                cur_ch  <= mem_ch[rd_ptr];
                cur_en  <= mem_en[rd_ptr];
            end
            latch_out <= to_strobe ? sel : '0;
            if (to_strobe) oe_out <= cur_en ? (oe_out | sel) : (oe_out & ~sel);
            err_ch <= (accept && ch_bad) ? 1'b1 : err_clr ? 1'b0 : err_ch;
        end
    end
endmodule

// File: tb/tb_pwm_ton_sequencer.sv
// tb_pwm_ton_sequencer: directed checks of the Ton sequencer at default and stretched setup/hold timing
module tb_pwm_ton_sequencer;
    localparam int NB_CH = 25;
    localparam int TON_W = 11;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0, req_en = 1'b0, err_clr = 1'b0;
    logic [4:0]       req_ch = '0;
    logic [TON_W-1:0] req_ton = '0;
    logic             req_ready, busy, err_ch;
    logic [TON_W-1:0] ton_out;
    logic [NB_CH-1:0] latch_out, oe_out;

    logic             b_valid = 1'b0, b_en = 1'b0, b_clr = 1'b0;
    logic [4:0]       b_ch = '0;
    logic [TON_W-1:0] b_ton = '0;
    logic             b_ready, b_busy, b_err;
    logic [TON_W-1:0] b_ton_out;
    logic [NB_CH-1:0] b_latch, b_oe;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_ton_sequencer dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_ton(req_ton), .req_en(req_en), .ton_out(ton_out),
        .latch_out(latch_out), .oe_out(oe_out), .busy(busy), .err_ch(err_ch), .err_clr(err_clr)
    );

    pwm_ton_sequencer #(.SETUP_CYC(3), .HOLD_CYC(2)) dut_slow (
        .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_ch(b_ch), .req_ton(b_ton), .req_en(b_en), .ton_out(b_ton_out),
        .latch_out(b_latch), .oe_out(b_oe), .busy(b_busy), .err_ch(b_err), .err_clr(b_clr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] ch, input logic [TON_W-1:0] ton, input logic en);
        req_valid = v;
        req_ch    = ch;
        req_ton   = ton;
        req_en    = en;
    endtask

    initial begin
        int idx;
        logic rb;
        logic [8:0] rdy_exp;
        rdy_exp = 9'b010011111;

        // reset state
        step;
        step;
        chk("rst_ton", ton_out, 0);
        chk("rst_latch", latch_out, 0);
        chk("rst_oe", oe_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_ch, 0);
        chk("rst_ready", req_ready, 1);
        reset_n = 1'b1;
        step;

        // single update: ch3 ton500 en1
        drive(1, 5'd3, 11'd500, 1);
        step;
        drive(0, 0, 0, 0);
        chk("t1_busy_e0", busy, 1);
        chk("t1_ton_e0", ton_out, 0);
        step;
        chk("t1_ton_e1", ton_out, 500);
        chk("t1_latch_e1", latch_out, 0);
        step;
        chk("t1_latch_e2", latch_out, 64'h8);
        chk("t1_oe_e2", oe_out, 64'h8);
        step;
        chk("t1_latch_e3", latch_out, 0);
        chk("t1_ton_e3", ton_out, 500);
        chk("t1_busy_e3", busy, 1);
        step;
        chk("t1_busy_e4", busy, 0);

        // burst with req_valid held: ch 10..16, ton 100..106, en on even index
        idx = 0;
        for (int c = 0; c <= 22; c++) begin
            drive(idx < 7, 5'(10 + idx), 11'(100 + idx), idx % 2 == 0);
            rb = req_ready && req_valid;
            step;
            if (rb) idx++;
            if (c <= 8) chk($sformatf("t2_ready_c%0d", c), req_ready, rdy_exp[c]);
            if (c >= 2 && (c - 2) % 3 == 0) begin
                chk($sformatf("t2_latch_c%0d", c), latch_out, 64'(1) << (10 + (c - 2) / 3));
                chk($sformatf("t2_ton_c%0d", c), ton_out, 64'(100 + (c - 2) / 3));
            end else chk($sformatf("t2_latch_c%0d", c), latch_out, 0);
        end
        drive(0, 0, 0, 0);
        chk("t2_busy_end", busy, 0);
        chk("t2_oe_end", oe_out, 64'h15408);

        // invalid channel and sticky error
        drive(1, 5'd27, 11'd77, 1);
        step;
        drive(0, 0, 0, 0);
        chk("t3_err_set", err_ch, 1);
        chk("t3_busy", busy, 0);
        step;
        chk("t3_latch", latch_out, 0);
        step;
        chk("t3_latch2", latch_out, 0);
        chk("t3_err_sticky", err_ch, 1);
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        chk("t3_err_clr", err_ch, 0);
        drive(1, 5'd28, 11'd88, 0);
        err_clr = 1'b1;
        step;
        drive(0, 0, 0, 0);
        err_clr = 1'b0;
        chk("t3_err_wins", err_ch, 1);
        chk("t3_busy2", busy, 0);
        chk("t3_oe_keep", oe_out, 64'h15408);
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;

        // broadcast: set all, then clear all with ton 0
        drive(1, 5'h1F, 11'd5, 1);
        step;
        drive(0, 0, 0, 0);
        step;
        step;
        chk("t4_latch_all1", latch_out, 64'h1FFFFFF);
        chk("t4_oe_all1", oe_out, 64'h1FFFFFF);
        step;
        step;
        drive(1, 5'h1F, 11'd0, 0);
        step;
        drive(0, 0, 0, 0);
        step;
        chk("t4_ton0", ton_out, 0);
        step;
        chk("t4_latch_all0", latch_out, 64'h1FFFFFF);
        chk("t4_oe_clr", oe_out, 0);
        step;
        chk("t4_latch_off", latch_out, 0);
        step;
        chk("t4_busy", busy, 0);

        // reset during setup discards everything
        drive(1, 5'd7, 11'd33, 1);
        step;
        drive(1, 5'd8, 11'd44, 1);
        step;
        drive(0, 0, 0, 0);
        chk("t5_ton_pre", ton_out, 33);
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        chk("t5_ton", ton_out, 0);
        chk("t5_latch", latch_out, 0);
        chk("t5_oe", oe_out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_err", err_ch, 0);
        chk("t5_ready", req_ready, 1);
        for (int c = 0; c < 5; c++) begin
            step;
            chk($sformatf("t5_latch_c%0d", c), latch_out, 0);
            chk($sformatf("t5_busy_c%0d", c), busy, 0);
        end

        // stretched timing instance: setup 3, hold 2
        for (int c = 0; c <= 13; c++) begin
            b_valid = c <= 1;
            b_ch    = c == 0 ? 5'd1 : 5'd2;
            b_ton   = c == 0 ? 11'd300 : 11'd400;
            b_en    = 1'b1;
            step;
            chk($sformatf("t6_ton_c%0d", c), b_ton_out, c == 0 ? 0 : c <= 6 ? 300 : 400);
            chk($sformatf("t6_latch_c%0d", c), b_latch, c == 4 ? 2 : c == 10 ? 4 : 0);
        end
        b_valid = 1'b0;
        chk("t6_busy", b_busy, 0);
        chk("t6_oe", b_oe, 64'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
